pwm_regs_multi: RTL and testbench



---
 rtl/pwm_regs_multi_if.sv | 13 +
 rtl/pwm_regs_multi.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_regs_multi.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_regs_multi_if.sv
// Byte-wide register access bus between the SPI/decoder side and pwm_regs_multi.
interface pwm_regs_multi_if #(
  parameter int ADDR_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_write;
  logic [7:0]        data_read;

  modport master (output read, write, addr, data_write, input data_read);
  modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/pwm_regs_multi.sv
// Multi-channel PWM register bank with double-buffered timing registers.
// Optional write lock at 0x0E enabled by defining PWM_REGS_WLOCK_EN.
module pwm_regs_multi #(
  parameter int CHANNELS  = 4,
  parameter int COUNTER_W = 16,
  parameter int ADDR_W    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  pwm_regs_multi_if.slave                 bus,
  input  logic                            period_evt,
  input  logic [COUNTER_W-1:0]            counter_val,
  output logic [COUNTER_W-1:0]            period,
  output logic                            en,
  output logic                            count_reset,
  output logic                            upnotdown,
  output logic [7:0]                      prescale,
  output logic [CHANNELS-1:0]             pwm_en,
  output logic [8*CHANNELS-1:0]           functions,
  output logic [COUNTER_W*CHANNELS-1:0]   compare1,
  output logic [COUNTER_W*CHANNELS-1:0]   compare2
);
  localparam int         NB         = COUNTER_W / 8;
  localparam int         CHW        = ADDR_W - 4;
  localparam logic [3:0] OFF_C1     = 4'd2;
  localparam logic [3:0] OFF_C1_END = 4'(2 + NB);
  localparam logic [3:0] OFF_C2     = 4'd6;
  localparam logic [3:0] OFF_C2_END = 4'(6 + NB);

  logic [3:0]     offset;
  logic [CHW-1:0] page;
  logic           glob_page;
  logic           wr_glob;
  logic           staged_ok;
  logic           glob_staged_wr;
  logic           force_upd;
  logic           commit;
  logic           any_staged_wr;

  logic [COUNTER_W-1:0] period_stg_reg, period_reg;
  logic [7:0]           prescale_stg_reg, prescale_reg;
  logic                 en_reg, upnotdown_reg, count_reset_reg;
  logic                 pending_reg, evt_seen_reg;
  logic [7:0]           data_read_reg;
  logic [7:0]           rd_next;

  logic [CHANNELS-1:0]   ch_hit;
  logic [CHANNELS-1:0]   ch_staged_wr;
  logic [8*CHANNELS-1:0] ch_rdata;

  assign offset    = bus.addr[3:0];
  assign page      = bus.addr[ADDR_W-1:4];
  assign glob_page = (page == '0);
  assign wr_glob   = bus.write && glob_page;

`ifdef PWM_REGS_WLOCK_EN
  logic unlocked_reg;
  assign staged_ok = unlocked_reg;
`else
  assign staged_ok = 1'b1;
`endif

  assign glob_staged_wr = wr_glob && staged_ok && ((offset < 4'(NB)) || (offset == 4'd5));
  assign force_upd      = wr_glob && staged_ok && (offset == 4'd7) && bus.data_write[0];
  // Commit copies the pre-write staging values; a same-cycle write keeps pending set.
  assign commit         = pending_reg && (period_evt || force_upd);
  assign any_staged_wr  = glob_staged_wr || (|ch_staged_wr);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                 ch_wr;
    logic                 pwm_en_reg;
    logic [7:0]           func_stg_reg, func_reg;
    logic [COUNTER_W-1:0] cmp1_stg_reg, cmp1_reg;
    logic [COUNTER_W-1:0] cmp2_stg_reg, cmp2_reg;
    logic [7:0]           rdata;

    assign ch_hit[gi]       = (page == CHW'(gi + 1));
    assign ch_wr            = bus.write && ch_hit[gi];
    assign ch_staged_wr[gi] = ch_wr && staged_ok &&
                              ((offset == 4'd1) ||
                               (offset >= OFF_C1 && offset < OFF_C1_END) ||
                               (offset >= OFF_C2 && offset < OFF_C2_END));

    always_ff @(posedge clk) begin
      if (rst) begin
        pwm_en_reg   <= 1'b0;
        func_stg_reg <= '0;
        func_reg     <= '0;
        cmp1_stg_reg <= '0;
        cmp1_reg     <= '0;
        cmp2_stg_reg <= '0;
        cmp2_reg     <= '0;
      end else begin
        if (ch_wr && offset == 4'd0) pwm_en_reg <= bus.data_write[0];
        if (ch_wr && staged_ok) begin
          if (offset == 4'd1) func_stg_reg <= bus.data_write;
          for (int i = 0; i < NB; i++) begin
            if (offset == 4'(2 + i)) cmp1_stg_reg[8*i +: 8] <= bus.data_write;
            if (offset == 4'(6 + i)) cmp2_stg_reg[8*i +: 8] <= bus.data_write;
          end
        end
        if (commit) begin
          func_reg <= func_stg_reg;
          cmp1_reg <= cmp1_stg_reg;
          cmp2_reg <= cmp2_stg_reg;
        end
      end
    end

    always_comb begin
      rdata = 8'h00;
      if (offset == 4'd0) rdata = {7'b0, pwm_en_reg};
      if (offset == 4'd1) rdata = func_stg_reg;
      for (int i = 0; i < NB; i++) begin
        if (offset == 4'(2 + i)) rdata = cmp1_stg_reg[8*i +: 8];
        if (offset == 4'(6 + i)) rdata = cmp2_stg_reg[8*i +: 8];
      end
    end

    assign ch_rdata[8*gi +: 8]                = rdata;
    assign pwm_en[gi]                         = pwm_en_reg;
    assign functions[8*gi +: 8]               = func_reg;
    assign compare1[COUNTER_W*gi +: COUNTER_W] = cmp1_reg;
    assign compare2[COUNTER_W*gi +: COUNTER_W] = cmp2_reg;
  end

  always_comb begin
    rd_next = 8'h00;
    if (glob_page) begin
      for (int i = 0; i < NB; i++) begin
        if (offset == 4'(i))     rd_next = period_stg_reg[8*i +: 8];
        if (offset == 4'(8 + i)) rd_next = counter_val[8*i +: 8];
      end
      if (offset == 4'd4) rd_next = {6'b0, upnotdown_reg, en_reg};
      if (offset == 4'd5) rd_next = prescale_stg_reg;
      if (offset == 4'd6) rd_next = {6'b0, evt_seen_reg, pending_reg};
`ifdef PWM_REGS_WLOCK_EN
      if (offset == 4'd14) rd_next = {7'b0, unlocked_reg};
`endif
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_hit[c]) rd_next = ch_rdata[8*c +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_stg_reg   <= '0;
      period_reg       <= '0;
      prescale_stg_reg <= '0;
      prescale_reg     <= '0;
      en_reg           <= 1'b0;
      upnotdown_reg    <= 1'b0;
      count_reset_reg  <= 1'b0;
      pending_reg      <= 1'b0;
      evt_seen_reg     <= 1'b0;
      data_read_reg    <= '0;
    end else begin
      count_reset_reg <= wr_glob && (offset == 4'd4) && bus.data_write[2];
      if (wr_glob && offset == 4'd4) begin
        en_reg        <= bus.data_write[0];
        upnotdown_reg <= bus.data_write[1];
      end
      if (wr_glob && staged_ok) begin
        for (int i = 0; i < NB; i++) begin
          if (offset == 4'(i)) period_stg_reg[8*i +: 8] <= bus.data_write;
        end
        if (offset == 4'd5) prescale_stg_reg <= bus.data_write;
      end
      // A new event outranks a simultaneous clear.
      if (period_evt)
        evt_seen_reg <= 1'b1;
      else if (wr_glob && offset == 4'd6 && bus.data_write[1])
        evt_seen_reg <= 1'b0;
      if (any_staged_wr)
        pending_reg <= 1'b1;
      else if (commit)
        pending_reg <= 1'b0;
      if (commit) begin
        period_reg   <= period_stg_reg;
        prescale_reg <= prescale_stg_reg;
      end
      if (bus.read) data_read_reg <= rd_next;
    end
  end

`ifdef PWM_REGS_WLOCK_EN
  always_ff @(posedge clk) begin
    if (rst)
      unlocked_reg <= 1'b0;
    else if (wr_glob && offset == 4'd14)
      unlocked_reg <= (bus.data_write == 8'hA5);
  end
`endif

  assign bus.data_read = data_read_reg;
  assign period        = period_reg;
  assign prescale      = prescale_reg;
  assign en            = en_reg;
  assign upnotdown     = upnotdown_reg;
  assign count_reset   = count_reset_reg;
endmodule

// File: tb/tb_pwm_regs_multi.sv
// Randomized bench for pwm_regs_multi against a byte-addressed register-file model.
module tb_pwm_regs_multi;
  localparam int CH        = 4;
  localparam int COUNTER_W = 16;
  localparam int ADDR_W    = 8;
  localparam int NB        = COUNTER_W / 8;

  logic clk;
  logic rst;
  logic period_evt;
  logic [COUNTER_W-1:0]    counter_val;
  logic [COUNTER_W-1:0]    period;
  logic                    en, count_reset, upnotdown;
  logic [7:0]              prescale;
  logic [CH-1:0]           pwm_en;
  logic [8*CH-1:0]         functions;
  logic [COUNTER_W*CH-1:0] compare1, compare2;

  pwm_regs_multi_if #(.ADDR_W(ADDR_W)) bus_if ();

  pwm_regs_multi #(.CHANNELS(CH), .COUNTER_W(COUNTER_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave),
    .period_evt(period_evt), .counter_val(counter_val),
    .period(period), .en(en), .count_reset(count_reset), .upnotdown(upnotdown),
    .prescale(prescale), .pwm_en(pwm_en), .functions(functions),
    .compare1(compare1), .compare2(compare2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: staged registers live in a byte array indexed by bus address.
  logic [7:0]    stg [256];
  logic [7:0]    act [256];
  logic          m_en, m_ud, m_cr, m_pending, m_evt, m_unlock;
  logic [CH-1:0] m_pwm_en;
  logic [7:0]    m_dr;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_staged(input logic [7:0] a);
    int pg  = int'(a[7:4]);
    int off = int'(a[3:0]);
    if (pg == 0) return (off < NB) || (off == 5);
    if (pg >= 1 && pg <= CH)
      return (off == 1) || (off >= 2 && off < 2 + NB) || (off >= 6 && off < 6 + NB);
    return 1'b0;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a, input logic [COUNTER_W-1:0] cv);
    int pg  = int'(a[7:4]);
    int off = int'(a[3:0]);
    if (is_staged(a)) return stg[a];
    if (a == 8'h04) return {6'b0, m_ud, m_en};
    if (a == 8'h06) return {6'b0, m_evt, m_pending};
    if (pg == 0 && off >= 8 && off < 8 + NB) return cv[8*(off-8) +: 8];
`ifdef PWM_REGS_WLOCK_EN
    if (a == 8'h0E) return {7'b0, m_unlock};
`endif
    if (pg >= 1 && pg <= CH && off == 0) return {7'b0, m_pwm_en[pg-1]};
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      stg[i] = 8'h00;
      act[i] = 8'h00;
    end
    m_en = 0; m_ud = 0; m_cr = 0; m_pending = 0; m_evt = 0; m_unlock = 0;
    m_pwm_en = '0;
    m_dr = 8'h00;
  endtask

  task automatic model_step(input logic r, input logic rd, input logic wr, input logic [7:0] a,
                            input logic [7:0] d, input logic evt, input logic [COUNTER_W-1:0] cv);
    logic [7:0] pre;
    logic ok, cm, sw;
    int pg;
    if (r) begin
      model_reset();
      return;
    end
`ifdef PWM_REGS_WLOCK_EN
    ok = m_unlock;
`else
    ok = 1'b1;
`endif
    pre = model_read(a, cv);
    cm  = m_pending && (evt || (wr && a == 8'h07 && d[0] && ok));
    sw  = wr && ok && is_staged(a);
    if (cm) act = stg;
    if (sw) stg[a] = d;
    if (sw) m_pending = 1'b1;
    else if (cm) m_pending = 1'b0;
    m_cr = wr && a == 8'h04 && d[2];
    if (wr && a == 8'h04) begin
      m_en = d[0];
      m_ud = d[1];
    end
    if (evt) m_evt = 1'b1;
    else if (wr && a == 8'h06 && d[1]) m_evt = 1'b0;
    pg = int'(a[7:4]);
    if (wr && a[3:0] == 4'd0 && pg >= 1 && pg <= CH) m_pwm_en[pg-1] = d[0];
`ifdef PWM_REGS_WLOCK_EN
    if (wr && a == 8'h0E) m_unlock = (d == 8'hA5);
`endif
    if (rd) m_dr = pre;
  endtask

  task automatic compare_all();
    logic [COUNTER_W-1:0]    e_per;
    logic [8*CH-1:0]         e_fn;
    logic [COUNTER_W*CH-1:0] e_c1, e_c2;
    for (int i = 0; i < NB; i++) e_per[8*i +: 8] = act[i];
    for (int c = 0; c < CH; c++) begin
      e_fn[8*c +: 8] = act[16 + 16*c + 1];
      for (int i = 0; i < NB; i++) begin
        e_c1[COUNTER_W*c + 8*i +: 8] = act[16 + 16*c + 2 + i];
        e_c2[COUNTER_W*c + 8*i +: 8] = act[16 + 16*c + 6 + i];
      end
    end
    check_val("data_read", bus_if.data_read, m_dr);
    check_val("period", period, e_per);
    check_val("prescale", prescale, act[5]);
    check_val("en", en, m_en);
    check_val("upnotdown", upnotdown, m_ud);
    check_val("count_reset", count_reset, m_cr);
    check_val("pwm_en", pwm_en, m_pwm_en);
    check_val("functions", functions, e_fn);
    check_val("compare1", compare1, e_c1);
    check_val("compare2", compare2, e_c2);
  endtask

  task automatic cycle(input logic r, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input logic evt);
    rst = r;
    bus_if.read = rd;
    bus_if.write = wr;
    bus_if.addr = a;
    bus_if.data_write = d;
    period_evt = evt;
    counter_val = COUNTER_W'($urandom);
    model_step(r, rd, wr, a, d, evt, counter_val);
    @(posedge clk);
    #1;
    if (rd || wr)
      $display("txn rst=%0d rd=%0d wr=%0d addr=%02h wdata=%02h evt=%0d rdata=%02h",
               r, rd, wr, a, d, evt, bus_if.data_read);
    compare_all();
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [7:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic idle(input logic evt);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, evt);
  endtask

  initial begin
    logic [7:0] ra, rdv;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h05, 8'hFF, 1'b1);

    // Reset state: every address reads zero (or the live counter), outputs idle.
    check_val("rst_period", period, 0);
    check_val("rst_count_reset", count_reset, 0);
    for (int a = 0; a < 16 * (CH + 1); a++) rd_reg(8'(a));

`ifdef PWM_REGS_WLOCK_EN
    wr_reg(8'h0E, 8'hA5);
`endif
    // Period staging and commit on period_evt.
    wr_reg(8'h00, 8'h34);
    wr_reg(8'h01, 8'h12);
    idle(1'b0);
    check_val("per_staged_hold", period, 16'h0000);
    rd_reg(8'h00);
    check_val("per_stg_read", bus_if.data_read, 8'h34);
    rd_reg(8'h06);
    check_val("status_pending", bus_if.data_read, 8'h01);
    idle(1'b1);
    check_val("per_commit", period, 16'h1234);
    rd_reg(8'h06);
    check_val("status_evt", bus_if.data_read, 8'h02);

    // Forced update of channel 2 compare1.
    wr_reg(8'h32, 8'h00);
    wr_reg(8'h33, 8'h02);
    wr_reg(8'h07, 8'h01);
    check_val("ch2_cmp1", compare1[COUNTER_W*2 +: COUNTER_W], 16'h0200);
    check_val("ch1_cmp1", compare1[COUNTER_W*1 +: COUNTER_W], 16'h0000);

    // CTRL: immediate enable and one-cycle count_reset.
    wr_reg(8'h04, 8'h05);
    check_val("ctrl_en", en, 1'b1);
    check_val("ctrl_cr_pulse", count_reset, 1'b1);
    rd_reg(8'h04);
    check_val("ctrl_cr_gone", count_reset, 1'b0);
    check_val("ctrl_read", bus_if.data_read, 8'h01);

    // Staging write together with period_evt while nothing is pending.
    cycle(1'b0, 1'b0, 1'b1, 8'h05, 8'h07, 1'b1);
    check_val("presc_no_commit", prescale, 8'h00);
    rd_reg(8'h06);
    check_val("presc_pending", bus_if.data_read[0], 1'b1);
    idle(1'b1);
    check_val("presc_commit", prescale, 8'h07);

`ifdef PWM_REGS_WLOCK_EN
    wr_reg(8'h0E, 8'h00);
    wr_reg(8'h00, 8'hFF);
    rd_reg(8'h06);
    check_val("lock_pend0", bus_if.data_read[0], 1'b0);
    rd_reg(8'h00);
    check_val("lock_stg", bus_if.data_read, 8'h34);
    wr_reg(8'h0E, 8'hA5);
    wr_reg(8'h00, 8'hFF);
    rd_reg(8'h06);
    check_val("unlock_pend1", bus_if.data_read[0], 1'b1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 1) == 1)
        ra = 8'($urandom_range(0, 15));
      else
        ra = 8'($urandom_range(16, 16 * (CH + 1) + 15));
      rdv = 8'($urandom);
      if (ra == 8'h0E && $urandom_range(0, 1) == 1) rdv = 8'hA5;
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1,
            ra, rdv,
            $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
